// File: rtl/max_tracker_pkg.sv
// max_tracker_pkg: shared state type and parameter helpers for the max tracker
package max_tracker_pkg;
  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;
  function automatic int idxw(input int epoch);
    return (epoch > 2) ? $clog2(epoch) : 1;
  endfunction
  function automatic logic [31:0] maxv(input int width, input bit sgn);
    return (32'h1 << (sgn ? width - 1 : width)) - 32'h1;
  endfunction
endpackage

// File: rtl/max_tracker_fsm_cmp.sv
// max_cmp: greater-than compare, unsigned or two's-complement
module max_cmp #(
  parameter int WIDTH = 8,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt
);
  assign gt = (SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b);
endmodule

// File: rtl/max_tracker_fsm.sv
// max_tracker_fsm: per-epoch running maximum with index, saturation lock and epoch result
module max_tracker_fsm
  import max_tracker_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int EPOCH = 16,
  parameter int SIGNED = 0,
  localparam int IDXW = idxw(EPOCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic [WIDTH-1:0] out_max,
  output logic [IDXW-1:0]  out_idx,
  output logic             max_valid,
  output logic             saturated,
  output logic             epoch_done,
  output logic [WIDTH-1:0] epoch_max
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(maxv(WIDTH, SIGNED != 0));
  localparam logic [IDXW-1:0] LAST = IDXW'(EPOCH - 1);
  state_t state, state_n;
  logic [IDXW-1:0] cnt, cnt_n, idx_n;
  logic [WIDTH-1:0] max_n, emax_n;
  logic valid_n, sat_n, done_n, gt, upd;
  max_cmp #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cmp (.a(in_data), .b(out_max), .gt(gt));
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      out_max <= '0;
      out_idx <= '0;
      max_valid <= 1'b0;
      saturated <= 1'b0;
      epoch_done <= 1'b0;
      epoch_max <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      out_max <= max_n;
      out_idx <= idx_n;
      max_valid <= valid_n;
      saturated <= sat_n;
      epoch_done <= done_n;
      epoch_max <= emax_n;
    end
  end
  // next state: clear beats samples, illegal encodings fall back to IDLE, last sample closes the epoch
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    max_n = out_max;
    idx_n = out_idx;
    valid_n = max_valid;
    sat_n = saturated;
    done_n = 1'b0;
    emax_n = epoch_max;
    upd = 1'b0;
    if (clear) begin
      state_n = IDLE;
      cnt_n = '0;
      valid_n = 1'b0;
      sat_n = 1'b0;
    end else if (state != IDLE && state != TRACK && state != LOCKED) begin
      state_n = IDLE;
    end else if (in_valid) begin
      upd = (state == IDLE) || (state == TRACK && gt);
      max_n = upd ? in_data : out_max;
      idx_n = upd ? cnt : out_idx;
      valid_n = 1'b1;
      sat_n = saturated || (in_data == MAXV);
      state_n = (in_data == MAXV) ? LOCKED : (state == IDLE ? TRACK : state);
      cnt_n = cnt + IDXW'(1);
      if (cnt == LAST) begin
        done_n = 1'b1;
        emax_n = max_n;
        cnt_n = '0;
        state_n = IDLE;
        valid_n = 1'b0;
        sat_n = 1'b0;
      end
    end
  end
endmodule

// File: doc/max_tracker_fsm.md
MAX_TRACKER_FSM -- requirements
Module: max_tracker_fsm

Interface
REQ-001 Parameter WIDTH, default 8: sample width in bits, legal range 2..32.
REQ-002 Parameter EPOCH, default 16: valid samples per epoch, legal range 2..256.
REQ-003 Parameter SIGNED, default 0: 0 selects unsigned compare, 1 selects two's-complement compare.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port in_valid, input, 1 bit: in_data is sampled this cycle.
REQ-007 Port in_data, input, WIDTH bits: sample value.
REQ-008 Port clear, input, 1 bit: synchronous restart of the current epoch.
REQ-009 Port out_max, output, WIDTH bits: highest sample seen so far in the current epoch.
REQ-010 Port out_idx, output, IDXW = max(1, $clog2(EPOCH)) bits: epoch position of out_max.
REQ-011 Port max_valid, output, 1 bit: out_max and out_idx hold a real sample.
REQ-012 Port saturated, output, 1 bit: the largest representable value has been seen this epoch.
REQ-013 Port epoch_done, output, 1 bit: one-cycle pulse marking epoch completion.
REQ-014 Port epoch_max, output, WIDTH bits: final maximum of the last completed epoch.

Function
REQ-015 The block SHALL implement FSM states IDLE (no sample yet this epoch), TRACK (comparing) and LOCKED (saturated; compare disabled).
REQ-016 All outputs SHALL be registered, with 1-cycle latency: a sample accepted at edge k is reflected in the outputs immediately after edge k.
REQ-017 In IDLE, on in_valid, the block SHALL load out_max = in_data and out_idx = cnt, set max_valid = 1 and go to TRACK.
REQ-018 In TRACK, on in_valid, the block SHALL update out_max/out_idx only if in_data > out_max, using the compare selected by SIGNED.
REQ-019 On a tie, the block SHALL keep the earlier index.
REQ-020 On any accepted sample equal to MAXV, the block SHALL enter LOCKED and set saturated = 1. MAXV is all-ones when unsigned, 2^(WIDTH-1)-1 when signed.
REQ-021 In LOCKED, the block SHALL count valid samples but SHALL NOT change out_max or out_idx.
REQ-022 Counter cnt SHALL range 0..EPOCH-1 and increment once per in_valid cycle.
REQ-023 On the valid sample taken when cnt = EPOCH-1, the block SHALL:
  - pulse epoch_done for exactly one cycle;
  - load epoch_max with the maximum including that sample;
  - wrap cnt to 0;
  - return to IDLE, clearing max_valid and saturated.
  out_max and out_idx SHALL hold their values.
REQ-024 epoch_max SHALL hold its value until the next epoch completes.
REQ-025 clear SHALL force IDLE, set cnt = 0 and deassert max_valid and saturated; epoch_max SHALL be unaffected and epoch_done SHALL NOT pulse.
REQ-026 When clear and in_valid are asserted in the same cycle, clear SHALL win and the sample SHALL be dropped.
REQ-027 Cycles with in_valid = 0 SHALL change no state.
REQ-028 Unreachable state encodings SHALL recover to IDLE.

Reset
REQ-029 While rst = 1 at a clock edge, the block SHALL enter IDLE with all of the following zero: cnt, out_max, out_idx, max_valid, saturated, epoch_done, epoch_max.
REQ-030 rst SHALL take priority over clear and in_valid.
REQ-031 rst asserted mid-epoch SHALL discard the partial epoch without pulsing epoch_done.

Structure
REQ-032 A shared package max_tracker_pkg SHALL hold:
  - the state enum (IDLE, TRACK, LOCKED);
  - the IDXW computation function;
  - the MAXV computation function.
REQ-033 The comparator SHALL be one sub-module, max_cmp, taking parameters WIDTH and SIGNED and producing a single greater-than output; FSM, counter and registers stay in max_tracker_fsm.

Verification
REQ-034 The bench SHALL cover the following directed scenarios, run with WIDTH=8 and EPOCH=4 unless stated:
  - Basic epoch (SIGNED=0): samples 3, 7, 7, 2 -> out_max 3, 7, 7, 7; out_idx 0, 1, 1, 1; epoch_done pulses after the 4th sample; epoch_max = 7; max_valid = 0 on the next cycle.
  - Signed compare (SIGNED=1): samples 0x80, 0xFB, 0x05, 0x04 -> out_max 0x80, 0xFB, 0x05, 0x05; epoch_max = 0x05.
  - Saturation (SIGNED=0): samples 0x10, 0xFF, 0x20, 0x01 -> saturated = 1 after the 2nd sample; out_max stays 0xFF with out_idx 1; epoch_done pulses with epoch_max = 0xFF; saturated = 0 afterwards.
  - Clear collision: samples 9, 4, then clear together with in_valid (data 0x50) -> sample dropped, IDLE, cnt = 0; next sample 2 gives out_max = 2, out_idx = 0; epoch_max unchanged.
  - Valid gaps: in_valid low for 3 cycles mid-epoch -> outputs and cnt unchanged; epoch completes only after the 4th valid sample.
  - Reset mid-epoch: rst after 2 samples -> all outputs 0 on the next cycle, no epoch_done pulse; a new epoch starts at idx 0.
